stage_reg_skid: RTL and testbench

Parametrised pipeline stage register with valid/ready handshake, two-entry skid buffer, flush-to-bubble and per-stage Tnew aging. It generalises the fixed D/E/M/W inter-stage latches: one module carries PC, instruction, NUM_DATA payload words and Tnew, and is placed between any two pipeline stages. A downstream stall (out_ready low) is absorbed without a combinational ready path back to the upstream stage.

---
 rtl/stage_reg_skid.sv | 148 ++++++++++++++
 tb/tb_stage_reg_skid.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/stage_reg_skid.sv
// Pipeline stage register with a two-entry skid buffer, flush-to-bubble and Tnew aging.
// in_ready comes straight from state, so downstream stalls never reach upstream combinationally.
module stage_reg_skid #(
  parameter int                 DATA_W   = 32,
  parameter int                 NUM_DATA = 3,
  parameter int                 TNEW_W   = 2,
  parameter logic [DATA_W-1:0]  RESET_PC = DATA_W'(32'h3000),
  parameter bit                 TNEW_DEC = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_pc,
  input  logic [DATA_W-1:0]          in_instr,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [TNEW_W-1:0]          in_Tnew,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_pc,
  output logic [DATA_W-1:0]          out_instr,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [TNEW_W-1:0]          out_Tnew,
  output logic [1:0]                 occupancy
);

  // Encoding doubles as the entry count driven on occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]          pc;
    logic [DATA_W-1:0]          instr;
    logic [NUM_DATA*DATA_W-1:0] data;
    logic [TNEW_W-1:0]          tnew;
  } entry_t;

  function automatic entry_t bubble_entry();
    entry_t e;
    e.pc    = RESET_PC;
    e.instr = '0;
    e.data  = '0;
    e.tnew  = '0;
    return e;
  endfunction

  function automatic logic [TNEW_W-1:0] age_tnew(input logic [TNEW_W-1:0] t);
    if (TNEW_DEC && (t != '0)) begin
      age_tnew = t - TNEW_W'(1);
    end else begin
      age_tnew = t;
    end
  endfunction

  state_t state_r, state_nxt;
  entry_t main_r, main_nxt;
  entry_t skid_r, skid_nxt;
  entry_t incoming;
  logic   accept;
  logic   consume;

  assign in_ready  = (state_r != FULL);
  assign out_valid = (state_r != EMPTY);
  assign occupancy = state_r;
  assign out_pc    = main_r.pc;
  assign out_instr = main_r.instr;
  assign out_data  = main_r.data;
  assign out_Tnew  = main_r.tnew;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // Tnew is aged once on capture and then frozen while the entry waits.
  always_comb begin
    incoming.pc    = in_pc;
    incoming.instr = in_instr;
    incoming.data  = in_data;
    incoming.tnew  = age_tnew(in_Tnew);
  end

  // Next-state and entry updates; the main entry is rewritten to a bubble whenever it empties.
  always_comb begin
    state_nxt = state_r;
    main_nxt  = main_r;
    skid_nxt  = skid_r;
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = bubble_entry();
      skid_nxt  = bubble_entry();
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept) begin
            main_nxt  = incoming;
            state_nxt = ONE;
          end else begin
            state_nxt = EMPTY;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_nxt = incoming;
          end else if (accept) begin
            skid_nxt  = incoming;
            state_nxt = FULL;
          end else if (consume) begin
            main_nxt  = bubble_entry();
            state_nxt = EMPTY;
          end else begin
            state_nxt = ONE;
          end
        end
        FULL: begin
          if (consume) begin
            main_nxt  = skid_r;
            skid_nxt  = bubble_entry();
            state_nxt = ONE;
          end else begin
            state_nxt = FULL;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_nxt  = bubble_entry();
          skid_nxt  = bubble_entry();
        end
      endcase
    end
  end

  // State and both entries, cleared to bubbles on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= EMPTY;
      main_r  <= bubble_entry();
      skid_r  <= bubble_entry();
    end else begin
      state_r <= state_nxt;
      main_r  <= main_nxt;
      skid_r  <= skid_nxt;
    end
  end

endmodule

// File: tb/tb_stage_reg_skid.sv
// Bench for stage_reg_skid: directed scenarios plus randomized valid/ready traffic,
// all compared each cycle against a queue-based model of the buffer contents.
module tb_stage_reg_skid;

  localparam int DW = 32;
  localparam int ND = 3;
  localparam int TW = 2;
  localparam logic [DW-1:0] RPC = 32'h3000;

  logic            clk = 1'b0;
  logic            reset, flush, in_valid, out_ready;
  logic [DW-1:0]   in_pc, in_instr;
  logic [ND*DW-1:0] in_data;
  logic [TW-1:0]   in_Tnew;
  logic            in_ready, out_valid;
  logic [DW-1:0]   out_pc, out_instr;
  logic [ND*DW-1:0] out_data;
  logic [TW-1:0]   out_Tnew;
  logic [1:0]      occupancy;

  logic            nd_in_ready, nd_out_valid;
  logic [DW-1:0]   nd_out_pc, nd_out_instr;
  logic [ND*DW-1:0] nd_out_data;
  logic [TW-1:0]   nd_out_Tnew;
  logic [1:0]      nd_occupancy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0]    pc;
    logic [DW-1:0]    instr;
    logic [ND*DW-1:0] data;
    logic [TW-1:0]    tnew_raw;
  } item_t;

  item_t model_q[$];

  always #5 clk = ~clk;

  stage_reg_skid #(.DATA_W(DW), .NUM_DATA(ND), .TNEW_W(TW), .RESET_PC(RPC), .TNEW_DEC(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_data(in_data), .in_Tnew(in_Tnew),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_data(out_data), .out_Tnew(out_Tnew), .occupancy(occupancy)
  );

  stage_reg_skid #(.DATA_W(DW), .NUM_DATA(ND), .TNEW_W(TW), .RESET_PC(RPC), .TNEW_DEC(1'b0)) dut_nodec (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(nd_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_data(in_data), .in_Tnew(in_Tnew),
    .out_valid(nd_out_valid), .out_ready(out_ready), .out_pc(nd_out_pc), .out_instr(nd_out_instr),
    .out_data(nd_out_data), .out_Tnew(nd_out_Tnew), .occupancy(nd_occupancy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with what the model's queue implies.
  task automatic check_model();
    item_t h;
    logic [TW-1:0] dec;
    chk("occupancy", 128'(occupancy), 128'(model_q.size()));
    chk("in_ready", 128'(in_ready), 128'(model_q.size() < 2));
    chk("out_valid", 128'(out_valid), 128'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      h = model_q[0];
      dec = (h.tnew_raw == 0) ? h.tnew_raw : h.tnew_raw - 1;
      chk("out_pc", 128'(out_pc), 128'(h.pc));
      chk("out_instr", 128'(out_instr), 128'(h.instr));
      chk("out_data", 128'(out_data), 128'(h.data));
      chk("out_Tnew", 128'(out_Tnew), 128'(dec));
      chk("nodec_Tnew", 128'(nd_out_Tnew), 128'(h.tnew_raw));
    end else begin
      chk("bubble_pc", 128'(out_pc), 128'(RPC));
      chk("bubble_instr", 128'(out_instr), 128'(0));
      chk("bubble_data", 128'(out_data), 128'(0));
      chk("bubble_Tnew", 128'(out_Tnew), 128'(0));
    end
  endtask

  // One clock: decide transfers from the model's view before the edge, update it, then check.
  task automatic step();
    item_t cur;
    bit acc, con;
    cur.pc = in_pc; cur.instr = in_instr; cur.data = in_data; cur.tnew_raw = in_Tnew;
    acc = in_valid && (model_q.size() < 2);
    con = out_ready && (model_q.size() != 0);
    @(posedge clk);
    if (reset || flush) begin
      model_q.delete();
    end else begin
      if (con) void'(model_q.pop_front());
      if (acc) model_q.push_back(cur);
    end
    #1;
    check_model();
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] pc, input logic [TW-1:0] t, input logic ordy);
    in_valid  = v;
    in_pc     = pc;
    in_Tnew   = t;
    out_ready = ordy;
    in_instr  = $urandom;
    in_data   = {$urandom, $urandom, $urandom};
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    drive(1'b0, 32'h0, 2'd0, 1'b0);
    step(); step();
    reset = 1'b0;

    // Traffic interrupted by a two-cycle reset.
    drive(1'b1, 32'h4000, 2'd3, 1'b0); step();
    drive(1'b1, 32'h4004, 2'd2, 1'b0); step();
    reset = 1'b1; step(); step();
    reset = 1'b0;
    drive(1'b0, 32'h0, 2'd0, 1'b0); step();
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_out_pc", 128'(out_pc), 128'(32'h3000));
    chk("reset_in_ready", 128'(in_ready), 128'(1));

    // Streaming with Tnew aging.
    drive(1'b1, 32'h3000, 2'd2, 1'b1); step();
    chk("stream0_pc", 128'(out_pc), 128'(32'h3000));
    chk("stream0_Tnew", 128'(out_Tnew), 128'(1));
    drive(1'b1, 32'h3004, 2'd1, 1'b1); step();
    chk("stream1_pc", 128'(out_pc), 128'(32'h3004));
    chk("stream1_Tnew", 128'(out_Tnew), 128'(0));
    drive(1'b1, 32'h3008, 2'd0, 1'b1); step();
    chk("stream2_pc", 128'(out_pc), 128'(32'h3008));
    chk("stream2_Tnew", 128'(out_Tnew), 128'(0));
    drive(1'b0, 32'h0, 2'd0, 1'b1); step();
    chk("stream_drain", 128'(out_valid), 128'(0));

    // Stall into the skid entry, then drain in order.
    drive(1'b1, 32'h3010, 2'd1, 1'b0); step();
    drive(1'b1, 32'h3014, 2'd1, 1'b0); step();
    chk("stall_full_ready", 128'(in_ready), 128'(0));
    chk("stall_full_pc", 128'(out_pc), 128'(32'h3010));
    drive(1'b1, 32'h3018, 2'd1, 1'b0); step();
    chk("stall_hold_pc", 128'(out_pc), 128'(32'h3010));
    in_valid = 1'b1; out_ready = 1'b1; step();
    chk("stall_drain0", 128'(out_pc), 128'(32'h3014));
    chk("stall_ready_back", 128'(in_ready), 128'(1));
    step();
    chk("stall_drain1", 128'(out_pc), 128'(32'h3018));
    in_valid = 1'b0; step();
    chk("stall_empty", 128'(occupancy), 128'(0));

    // Flush while full with a simultaneous offer.
    drive(1'b1, 32'h301c, 2'd0, 1'b0); step();
    drive(1'b1, 32'h3024, 2'd0, 1'b0); step();
    flush = 1'b1;
    drive(1'b1, 32'h3020, 2'd2, 1'b1); step();
    flush = 1'b0;
    chk("flush_occ", 128'(occupancy), 128'(0));
    chk("flush_instr", 128'(out_instr), 128'(0));
    drive(1'b0, 32'h0, 2'd0, 1'b1); step(); step();
    chk("flush_dropped", 128'(out_valid), 128'(0));

    // Tnew saturation and pass-through build.
    drive(1'b1, 32'h3030, 2'd0, 1'b1); step();
    chk("tnew_sat", 128'(out_Tnew), 128'(0));
    drive(1'b1, 32'h3034, 2'd3, 1'b1); step();
    chk("tnew_dec3", 128'(out_Tnew), 128'(2));
    chk("tnew_nodec3", 128'(nd_out_Tnew), 128'(3));
    drive(1'b0, 32'h0, 2'd0, 1'b1); step();

    // Randomized handshake traffic with rare flushes.
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      flush = ($urandom_range(0, 63) == 0);
      step();
    end
    flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
